multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be asynchronous and active-high.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port reset, input, 1: asynchronous active-high reset.
REQ-004 Ports op[6:0], funct3[2:0], funct7b5, input: fields of the latched instruction register.
REQ-005 Port Zero, input, 1: ALU zero flag.
REQ-006 Ports ImmSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], output: datapath mux selects.
REQ-007 Ports AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, output, 1: datapath enables.
REQ-008 Port ALUControl[2:0], output: ALU operation code, 000 add, 001 sub, 010 or, 011 and, 101 slt.

Function
REQ-009 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-010 State SHALL advance on every rising clk edge; there are no stall inputs.
REQ-011 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: op 0000011 or 0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other op->FETCH.
- MEMADR: op 0000011->MEMREAD, else MEMWRITE.
- MEMREAD->MEMWB; MEMWB, MEMWRITE, BEQ->FETCH.
- EXECR, EXECI, JAL->ALUWB; ALUWB->FETCH.
REQ-012 Moore outputs per state SHALL be as listed; every unlisted output is 0:
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-013 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally, in the same cycle.
REQ-014 ImmSrc SHALL decode combinationally from op: 0100011->01, 1100011->10, 1101111->11, all others->00.
REQ-015 ALUControl SHALL decode combinationally:
- ALUOp 00->000; ALUOp 01->001.
- ALUOp 10 by funct3: 000->001 if op[5] AND funct7b5 else 000; 010->101; 110->010; 111->011; other->000.
REQ-016 ALUOp 11 SHALL never be produced; if decoded it SHALL yield 000.
REQ-017 Each instruction SHALL take these cycles, FETCH to the next FETCH exclusive: lw 5, sw 4, R/I 4, jal 4, beq 3, unknown op 2.
REQ-018 At most one of RegWrite, MemWrite SHALL be 1 in any cycle; IRWrite SHALL be 1 only in FETCH.

Reset
REQ-019 Asserting reset SHALL force state to FETCH immediately, independent of clk, including in mid-instruction.
REQ-020 While reset is high, outputs SHALL be the FETCH values with PCWrite forced to 0.
REQ-021 The first rising clk edge after reset deassertion SHALL leave FETCH for DECODE.

Structure
REQ-022 The state enum and the ALUControl, ALUOp and opcode constants SHALL live in shared package rv_ctrl_pkg.
REQ-023 The state register and next-state/output logic SHALL form the FSM.
REQ-024 ALU decoding (REQ-015) SHALL be sub-module alu_decoder.
REQ-025 The ImmSrc decode SHALL be inline.

Verification
REQ-026 The bench SHALL cover lw (op 0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 and ResultSrc=01 only in MEMWB.
REQ-027 The bench SHALL cover sub (op 0110011, funct3 000, funct7b5 1): ALUControl=001 in EXECR; addi with the same funct7b5 bit set (op 0010011) gives 000.
REQ-028 The bench SHALL cover beq with Zero=1: PCWrite=1 in BEQ; with Zero=0, PCWrite=0; both return to FETCH after 3 cycles.
REQ-029 The bench SHALL cover sw (op 0100011): ImmSrc=01; MemWrite=1 for exactly one cycle, in MEMWRITE; RegWrite stays 0 throughout.
REQ-030 The bench SHALL cover an unknown op (0000000): DECODE->FETCH with no write enables asserted.
REQ-031 The bench SHALL cover reset asserted between clk edges during MEMREAD: state becomes FETCH at once with PCWrite=0, and DECODE follows the first edge after release.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM states,
// ALU operation codes, ALUOp classes and the opcodes the decoder recognises.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // ALU operation codes driven on ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALUOp classes produced by the FSM (2'b11 is never generated)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp class plus instruction fields onto the
// concrete ALU operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic       i_op5,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic [1:0] i_alu_op,
    output logic [2:0] o_alu_control
);

    // Combinational decode; only R-type (op[5]=1) with funct7b5 selects sub,
    // so an immediate whose bit 30 happens to be set still adds.
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute
// with combinational PCWrite, ImmSrc and ALU decode.
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [2:0] ALUControl
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_alu_op;
    logic       w_branch;
    logic       w_pc_update;

    // State register; reset returns to FETCH without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Moore outputs per state; anything not set for a state stays 0
    always_comb begin
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        AdrSrc      = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        w_alu_op    = ALUOP_ADD;
        w_branch    = 1'b0;
        w_pc_update = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            default: begin
                ALUSrcA = 2'b00;
            end
        endcase
    end

    // PC enable: unconditional update or taken branch, suppressed during reset
    assign PCWrite = ~reset & (w_pc_update | (w_branch & Zero));

    // Immediate format select straight from the opcode
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_op5         (op[5]),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_alu_op      (w_alu_op),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction vector table driven
// through a cycle-level reference model with an expected-output queue.
module tb_multicycle_controller;

    typedef enum int {
        M_FETCH, M_DECODE, M_MEMADR, M_MEMREAD, M_MEMWB, M_MEMWRITE,
        M_EXECR, M_EXECI, M_ALUWB, M_BEQ, M_JAL
    } mstate_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         cycles;
        int         n_rw;
        int         n_mw;
        logic [1:0] imm;
        logic [2:0] exec_alu;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
    logic [2:0] ALUControl;

    int         checks = 0;
    int         errors = 0;
    logic [15:0] sb_q[$];
    mstate_t    mstate;
    vec_t       vecs[13];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .ALUControl (ALUControl)
    );

    // Bit layout: ImmSrc[15:14] SrcA[13:12] SrcB[11:10] Res[9:8] Adr[7] IR[6] PC[5] RW[4] MW[3] ALUC[2:0]
    function automatic logic [15:0] pack_outs();
        return {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
                PCWrite, RegWrite, MemWrite, ALUControl};
    endfunction

    function automatic logic [2:0] model_alu(logic [1:0] aop);
        if (aop == 2'b01) return 3'b001;
        if (aop != 2'b10) return 3'b000;
        case (funct3)
            3'b000:  return (op[5] && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b010;
            3'b111:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] model_out(mstate_t s, logic rst_on);
        logic [1:0] imm, sa, sb, rs, aop;
        logic       adr, ir, rw, mw, br, pcu, pcw;
        imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
              (op == 7'b1101111) ? 2'b11 : 2'b00;
        sa = 0; sb = 0; rs = 0; aop = 0;
        adr = 0; ir = 0; rw = 0; mw = 0; br = 0; pcu = 0;
        case (s)
            M_FETCH:    begin ir = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
            M_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            M_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            M_MEMREAD:  adr = 1;
            M_MEMWB:    begin rs = 2'b01; rw = 1; end
            M_MEMWRITE: begin adr = 1; mw = 1; end
            M_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            M_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            M_ALUWB:    rw = 1;
            M_BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1; end
            M_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            default:    ;
        endcase
        pcw = !rst_on && (pcu || (br && Zero));
        return {imm, sa, sb, rs, adr, ir, pcw, rw, mw, model_alu(aop)};
    endfunction

    function automatic mstate_t model_next(mstate_t s);
        case (s)
            M_FETCH: return M_DECODE;
            M_DECODE: begin
                if (op == 7'b0000011 || op == 7'b0100011) return M_MEMADR;
                if (op == 7'b0110011) return M_EXECR;
                if (op == 7'b0010011) return M_EXECI;
                if (op == 7'b1100011) return M_BEQ;
                if (op == 7'b1101111) return M_JAL;
                return M_FETCH;
            end
            M_MEMADR:  return (op == 7'b0000011) ? M_MEMREAD : M_MEMWRITE;
            M_MEMREAD: return M_MEMWB;
            M_EXECR, M_EXECI, M_JAL: return M_ALUWB;
            default:   return M_FETCH;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock of operation: queue the model's prediction, compare at negedge, advance
    task automatic step_cycle(output logic [15:0] got, output mstate_t s_at);
        logic [15:0] exp;
        sb_q.push_back(model_out(mstate, 1'b0));
        @(negedge clk);
        got  = pack_outs();
        s_at = mstate;
        exp  = sb_q.pop_front();
        check($sformatf("outs_state%0d", s_at), got, exp);
        check("rw_mw_exclusive", {15'd0, got[4] & got[3]}, 16'd0);
        @(posedge clk);
        mstate = model_next(mstate);
        #1;
    endtask

    task automatic run_instr(input vec_t v);
        logic [15:0] got;
        mstate_t     s_at;
        int          n, rw, mw;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.zero;
        n = 0; rw = 0; mw = 0;
        do begin
            step_cycle(got, s_at);
            n++;
            rw += int'(got[4]);
            mw += int'(got[3]);
            if (s_at == M_EXECR || s_at == M_EXECI)
                check({v.name, "_aluctl"}, {13'd0, got[2:0]}, {13'd0, v.exec_alu});
            if (s_at == M_BEQ)
                check({v.name, "_pcwrite"}, {15'd0, got[5]}, {15'd0, v.zero});
            if (s_at == M_DECODE)
                check({v.name, "_immsrc"}, {14'd0, got[15:14]}, {14'd0, v.imm});
        end while (mstate != M_FETCH && n < 12);
        check({v.name, "_cycles"}, 16'(n), 16'(v.cycles));
        check({v.name, "_regwrite_cnt"}, 16'(rw), 16'(v.n_rw));
        check({v.name, "_memwrite_cnt"}, 16'(mw), 16'(v.n_mw));
    endtask

    initial begin
        logic [15:0] got;
        mstate_t     s_at;

        //          name     op           f3      f7    z     cyc rw mw imm    exec_alu
        vecs[0]  = '{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 5, 1, 0, 2'b00, 3'b000};
        vecs[1]  = '{"sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4, 0, 1, 2'b01, 3'b000};
        vecs[2]  = '{"sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4, 1, 0, 2'b00, 3'b001};
        vecs[3]  = '{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4, 1, 0, 2'b00, 3'b000};
        vecs[4]  = '{"addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 4, 1, 0, 2'b00, 3'b000};
        vecs[5]  = '{"slti",  7'b0010011, 3'b010, 1'b0, 1'b0, 4, 1, 0, 2'b00, 3'b101};
        vecs[6]  = '{"or",    7'b0110011, 3'b110, 1'b0, 1'b0, 4, 1, 0, 2'b00, 3'b010};
        vecs[7]  = '{"andi",  7'b0010011, 3'b111, 1'b1, 1'b0, 4, 1, 0, 2'b00, 3'b011};
        vecs[8]  = '{"sll",   7'b0110011, 3'b001, 1'b0, 1'b0, 4, 1, 0, 2'b00, 3'b000};
        vecs[9]  = '{"beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, 0, 0, 2'b10, 3'b000};
        vecs[10] = '{"beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 0, 0, 2'b10, 3'b000};
        vecs[11] = '{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4, 1, 0, 2'b11, 3'b000};
        vecs[12] = '{"unk",   7'b0000000, 3'b000, 1'b0, 1'b0, 2, 0, 0, 2'b00, 3'b000};

        // Power-on reset: FETCH outputs with PCWrite held low
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b1;
        mstate = M_FETCH;
        repeat (2) @(posedge clk);
        #2;
        sb_q.push_back(model_out(M_FETCH, 1'b1));
        check("reset_outs", pack_outs(), sb_q.pop_front());
        check("reset_pcwrite", {15'd0, PCWrite}, 16'd0);
        #1 reset = 1'b0;

        for (int i = 0; i < 13; i++) run_instr(vecs[i]);

        // lw interrupted by an asynchronous reset while in MEMREAD
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b1;
        for (int k = 0; k < 3; k++) step_cycle(got, s_at);
        check("pre_reset_memread", pack_outs(), model_out(M_MEMREAD, 1'b0));
        #2 reset = 1'b1;
        #1;
        mstate = M_FETCH;
        check("async_reset_outs", pack_outs(), model_out(M_FETCH, 1'b1));
        @(negedge clk);
        check("reset_hold_negedge", pack_outs(), model_out(M_FETCH, 1'b1));
        @(posedge clk);
        #1;
        check("reset_hold_posedge", pack_outs(), model_out(M_FETCH, 1'b1));
        #1 reset = 1'b0;
        run_instr(vecs[0]);
        run_instr(vecs[9]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
